synchronizer: RTL and testbench



---
 rtl/sync_pkg.sv | 22 ++
 rtl/sync_stage.sv | 30 +++
 rtl/synchronizer.sv | 49 ++++
 tb/tb_synchronizer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_pkg
// Description : Shared defaults, limits and helpers for the CDC synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_pkg;

    localparam int SYNC_DEFAULT_WIDTH  = 9;
    localparam int SYNC_DEFAULT_STAGES = 4;
    localparam int SYNC_MIN_STAGES     = 1;
    localparam int SYNC_MIN_WIDTH      = 1;

    // Convenience vector for callers using the default datapath width.
    typedef logic [SYNC_DEFAULT_WIDTH-1:0] sync_vec_t;

    function automatic bit sync_params_valid(input int width, input int stages);
        return (width >= SYNC_MIN_WIDTH) && (stages >= SYNC_MIN_STAGES);
    endfunction

endpackage : sync_pkg
`default_nettype wire

// File: rtl/sync_stage.sv
`default_nettype none
// ============================================================================
// Module      : sync_stage
// Description : One WIDTH-bit register with asynchronous active-high clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_stage #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    (* ASYNC_REG = "TRUE", dont_touch = "true" *)
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : sync_stage
`default_nettype wire

// File: rtl/synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : synchronizer
// Description : NUM_FFS-deep flip-flop chain carrying LOGIC_SIZE bits into
//               the i_new_clk domain; latency is exactly NUM_FFS edges.
// Revision    : 1.0 - initial release
// ============================================================================
module synchronizer
    import sync_pkg::*;
#(
    parameter int LOGIC_SIZE = SYNC_DEFAULT_WIDTH,
    parameter int NUM_FFS    = SYNC_DEFAULT_STAGES
) (
    input  logic                  i_new_clk,
    input  logic                  i_reset,
    input  logic [LOGIC_SIZE-1:0] i_input_data,
    output logic [LOGIC_SIZE-1:0] o_output_data
);

    generate
        if (!sync_params_valid(LOGIC_SIZE, NUM_FFS)) begin : g_param_error
            $fatal(1, "synchronizer: LOGIC_SIZE=%0d NUM_FFS=%0d, both must be >= 1",
                   LOGIC_SIZE, NUM_FFS);
        end
    endgenerate

    // Slot 0 is the raw input; slot k+1 is the output of stage k.
    logic [NUM_FFS:0][LOGIC_SIZE-1:0] w_chain;

    assign w_chain[0] = i_input_data;

    generate
        for (genvar k = 0; k < NUM_FFS; k++) begin : g_stage
            (* ASYNC_REG = "TRUE", dont_touch = "true" *)
            sync_stage #(
                .WIDTH (LOGIC_SIZE)
            ) u_stage (
                .i_clk (i_new_clk),
                .i_rst (i_reset),
                .i_d   (w_chain[k]),
                .o_q   (w_chain[k+1])
            );
        end
    endgenerate

    assign o_output_data = w_chain[NUM_FFS];

endmodule : synchronizer
`default_nettype wire

// File: tb/tb_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_synchronizer
// Description : Directed self-checking bench for synchronizer, five configs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synchronizer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [8:0]  din_m = '0, dout_m;   // LOGIC_SIZE=9,  NUM_FFS=4 (defaults)
    logic [0:0]  din_a = '0, dout_a;   // LOGIC_SIZE=1,  NUM_FFS=1
    logic [8:0]  din_b = '0, dout_b;   // LOGIC_SIZE=9,  NUM_FFS=2
    logic [31:0] din_c = '0, dout_c;   // LOGIC_SIZE=32, NUM_FFS=4
    logic [31:0] din_d = '0, dout_d;   // LOGIC_SIZE=32, NUM_FFS=1

    int checks   = 0;
    int failures = 0;

    logic [31:0] hm[$], ha[$], hb[$], hc[$], hd[$];

    always #5 clk = ~clk;

    synchronizer u_dut_m (
        .i_new_clk(clk), .i_reset(rst), .i_input_data(din_m), .o_output_data(dout_m));
    synchronizer #(.LOGIC_SIZE(1),  .NUM_FFS(1)) u_dut_a (
        .i_new_clk(clk), .i_reset(rst), .i_input_data(din_a), .o_output_data(dout_a));
    synchronizer #(.LOGIC_SIZE(9),  .NUM_FFS(2)) u_dut_b (
        .i_new_clk(clk), .i_reset(rst), .i_input_data(din_b), .o_output_data(dout_b));
    synchronizer #(.LOGIC_SIZE(32), .NUM_FFS(4)) u_dut_c (
        .i_new_clk(clk), .i_reset(rst), .i_input_data(din_c), .o_output_data(dout_c));
    synchronizer #(.LOGIC_SIZE(32), .NUM_FFS(1)) u_dut_d (
        .i_new_clk(clk), .i_reset(rst), .i_input_data(din_d), .o_output_data(dout_d));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_of(input logic [31:0] h[$], input int nf);
        if (h.size() < nf) return 32'h0;
        return h[h.size() - nf];
    endfunction

    task automatic clear_hist();
        hm.delete(); ha.delete(); hb.delete(); hc.delete(); hd.delete();
    endtask

    task automatic set_all(input logic [31:0] v);
        din_m = v[8:0]; din_a = v[0:0]; din_b = v[8:0]; din_c = v; din_d = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m"}, 32'(dout_m), 32'h0);
        check({tag, "_a"}, 32'(dout_a), 32'h0);
        check({tag, "_b"}, 32'(dout_b), 32'h0);
        check({tag, "_c"}, dout_c,      32'h0);
        check({tag, "_d"}, dout_d,      32'h0);
    endtask

    // One rising edge, then compare every instance against its input history.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) begin
            clear_hist();
        end else begin
            hm.push_back(32'(din_m)); ha.push_back(32'(din_a)); hb.push_back(32'(din_b));
            hc.push_back(din_c);      hd.push_back(din_d);
        end
        #1;
        check({tag, "_m"}, 32'(dout_m), exp_of(hm, 4));
        check({tag, "_a"}, 32'(dout_a), exp_of(ha, 1));
        check({tag, "_b"}, 32'(dout_b), exp_of(hb, 2));
        check({tag, "_c"}, dout_c,      exp_of(hc, 4));
        check({tag, "_d"}, dout_d,      exp_of(hd, 1));
    endtask

    initial begin
        // Reset with all-ones input: outputs clear without any clock edge.
        set_all(32'hFFFF_FFFF);
        #2 rst = 1'b1;
        clear_hist();
        #1 check_all_zero("rst_async");
        tick("rst_hold1");
        tick("rst_hold2");
        check("rst_hold_m", 32'(dout_m), 32'h0);

        // Constant 0x0A5 across release appears exactly 4 edges later.
        set_all(32'h0000_00A5);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick("rel_model");
            check($sformatf("rel_hold_e%0d", k), 32'(dout_m), (k < 4) ? 32'h0 : 32'h0A5);
        end

        // Step 0 -> 0x155.
        set_all(32'h0);
        for (int k = 0; k < 4; k++) tick("flush");
        check("flush_zero_m", 32'(dout_m), 32'h0);
        din_m = 9'h155;
        for (int k = 1; k <= 4; k++) begin
            tick("step_model");
            check($sformatf("step_e%0d", k), 32'(dout_m), (k < 4) ? 32'h0 : 32'h155);
        end

        // Mid-stream reset between edges while the chain holds 0x155.
        #2 rst = 1'b1;
        clear_hist();
        #1 check_all_zero("midrst_async");
        tick("midrst_hold");

        // Release with all-ones: per-config latency.
        set_all(32'hFFFF_FFFF);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick("ones_model");
            check($sformatf("ones_m_e%0d", k), 32'(dout_m), (k >= 4) ? 32'h1FF : 32'h0);
            check($sformatf("ones_a_e%0d", k), 32'(dout_a), (k >= 1) ? 32'h1 : 32'h0);
            check($sformatf("ones_b_e%0d", k), 32'(dout_b), (k >= 2) ? 32'h1FF : 32'h0);
            check($sformatf("ones_c_e%0d", k), dout_c, (k >= 4) ? 32'hFFFF_FFFF : 32'h0);
            check($sformatf("ones_d_e%0d", k), dout_d, (k >= 1) ? 32'hFFFF_FFFF : 32'h0);
        end

        // All-zero pattern following all-ones.
        set_all(32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick("zero_model");
            check($sformatf("zero_m_e%0d", k), 32'(dout_m), (k >= 4) ? 32'h0 : 32'h1FF);
            check($sformatf("zero_a_e%0d", k), 32'(dout_a), 32'h0);
            check($sformatf("zero_b_e%0d", k), 32'(dout_b), (k >= 2) ? 32'h0 : 32'h1FF);
            check($sformatf("zero_c_e%0d", k), dout_c, (k >= 4) ? 32'h0 : 32'hFFFF_FFFF);
            check($sformatf("zero_d_e%0d", k), dout_d, 32'h0);
        end

        // Fresh reset, then 32 random values, one per edge.
        #2 rst = 1'b1;
        clear_hist();
        #1 check_all_zero("rnd_rst");
        tick("rnd_rst_hold");
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            din_m = 9'($urandom);
            din_a = 1'($urandom);
            din_b = 9'($urandom);
            din_c = $urandom;
            din_d = $urandom;
            tick($sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_synchronizer
`default_nettype wire
